// File: rtl/updown_counter_gen_if.sv
// Host bus bundle for updown_counter_gen.
//   ncs_in       chip select, active low
//   nwr_in       write strobe, active low
//   nrd_in       read strobe, active low
//   addr_in      register address
//   din_in       write data
//   dout_out     registered read data
//   rd_valid_out one-clock pulse qualifying dout_out
// WIDTH must match the WIDTH of the counter it is attached to.
interface updown_counter_gen_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             ncs_in;
    logic             nwr_in;
    logic             nrd_in;
    logic [2:0]       addr_in;
    logic [WIDTH-1:0] din_in;
    logic [WIDTH-1:0] dout_out;
    logic             rd_valid_out;

    modport master (
        output ncs_in, nwr_in, nrd_in, addr_in, din_in,
        input  dout_out, rd_valid_out
    );

    modport slave (
        input  ncs_in, nwr_in, nrd_in, addr_in, din_in,
        output dout_out, rd_valid_out
    );
endinterface

// File: rtl/updown_counter_gen.sv
// Bus-programmed up/down counter. The host loads PLR/ULR/LLR/CCR/CTRL over the
// ncs/nwr/nrd bus; a rising edge on start_in runs CCR count cycles (or runs
// continuously) in bounce, up-wrap or down-wrap mode. ec_out pulses when the
// last cycle completes.
//   clk_in, reset_in  clock and synchronous active-high reset
//   bus               host register bus (slave side)
//   start_in          rising edge requests a run
//   stop_in           level, aborts a run
//   count_out         current count
//   dir_out           1 = last step up or hold, 0 = last step down
//   busy_out          run in progress
//   ec_out            one-clock end-of-count pulse
//   err_out           configuration error
module updown_counter_gen #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CCR_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    updown_counter_gen_if.slave   bus,
    input  logic                  start_in,
    input  logic                  stop_in,
    output logic [WIDTH-1:0]      count_out,
    output logic                  dir_out,
    output logic                  busy_out,
    output logic                  ec_out,
    output logic                  err_out
);

    localparam logic [WIDTH-1:0]     One    = WIDTH'(1);
    localparam logic [CCR_WIDTH-1:0] CcrOne = CCR_WIDTH'(1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     plr_q, ulr_q, llr_q, count_q, dout_q;
    logic [CCR_WIDTH-1:0] ccr_q, rem_q;
    logic [2:0]           ctrl_q;
    logic                 dir_q, hit_u_q, hit_l_q, ec_q, err_q, wr_err_q, rd_valid_q, start_q;

    logic                 busy, wr_en, rd_en, cfg_wr, locked_wr, accept, cont, cfg_err;
    logic [1:0]           mode;
    logic [WIDTH-1:0]     step_count, rd_data;
    logic                 step_dir, hit_u_n, hit_l_n, cycle_done, last_cycle;

    assign busy      = (state_q == StRun);
    assign mode      = ctrl_q[1:0];
    assign cont      = ctrl_q[2];
    assign wr_en     = !bus.ncs_in && !bus.nwr_in;
    assign rd_en     = !bus.ncs_in && !bus.nrd_in && bus.nwr_in;
    assign cfg_wr    = wr_en && (bus.addr_in <= 3'd4) && !busy;
    assign locked_wr = wr_en && (bus.addr_in <= 3'd4) && busy;
    // stop wins over a simultaneous start
    assign accept    = !busy && start_in && !start_q && !err_q && !stop_in;

    assign cfg_err = (plr_q < llr_q) || (plr_q > ulr_q) || (llr_q > ulr_q) ||
                     (mode == 2'b11) || ((ccr_q == '0) && !cont);

    // One counting step from the current position.
    always_comb begin
        step_count = count_q;
        step_dir   = dir_q;
        if (ulr_q == llr_q) begin
            // degenerate window: hold, each clock is a full cycle
            step_dir = 1'b1;
        end else begin
            case (mode)
                2'b00: begin
                    if (dir_q) begin
                        if (count_q == ulr_q) begin
                            step_count = count_q - One;
                            step_dir   = 1'b0;
                        end else begin
                            step_count = count_q + One;
                        end
                    end else begin
                        if (count_q == llr_q) begin
                            step_count = count_q + One;
                            step_dir   = 1'b1;
                        end else begin
                            step_count = count_q - One;
                        end
                    end
                end
                2'b01: begin
                    step_dir   = 1'b1;
                    step_count = (count_q == ulr_q) ? llr_q : count_q + One;
                end
                2'b10: begin
                    // the wrap jump leaves dir untouched
                    if (count_q == llr_q) begin
                        step_count = ulr_q;
                    end else begin
                        step_count = count_q - One;
                        step_dir   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arrival flags include this step; a wrap lands on the opposite limit and so sets it too.
    assign hit_u_n    = hit_u_q || (step_count == ulr_q);
    assign hit_l_n    = hit_l_q || (step_count == llr_q);
    assign cycle_done = (step_count == plr_q) && hit_u_n && hit_l_n;
    assign last_cycle = cycle_done && !cont && (rem_q == CcrOne);

    always_comb begin
        case (bus.addr_in)
            3'd0:    rd_data = plr_q;
            3'd1:    rd_data = ulr_q;
            3'd2:    rd_data = llr_q;
            3'd3:    rd_data = WIDTH'(ccr_q);
            3'd4:    rd_data = WIDTH'(ctrl_q);
            3'd5:    rd_data = WIDTH'({wr_err_q, err_q, busy, dir_q});
            3'd6:    rd_data = count_q;
            default: rd_data = WIDTH'(rem_q);
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (stop_in || last_cycle) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_out         = busy;
        count_out        = count_q;
        dir_out          = dir_q;
        ec_out           = ec_q;
        err_out          = err_q;
        bus.dout_out     = dout_q;
        bus.rd_valid_out = rd_valid_q;
    end

    // Registers and datapath
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            plr_q      <= '0;
            ulr_q      <= '1;
            llr_q      <= '0;
            ccr_q      <= CcrOne;
            ctrl_q     <= '0;
            rem_q      <= '0;
            count_q    <= '0;
            dir_q      <= 1'b1;
            hit_u_q    <= 1'b0;
            hit_l_q    <= 1'b0;
            ec_q       <= 1'b0;
            err_q      <= 1'b0;
            wr_err_q   <= 1'b0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            start_q    <= start_in;
            err_q      <= cfg_err;
            ec_q       <= 1'b0;
            rd_valid_q <= rd_en;

            if (cfg_wr) begin
                case (bus.addr_in)
                    3'd0:    plr_q  <= bus.din_in;
                    3'd1:    ulr_q  <= bus.din_in;
                    3'd2:    llr_q  <= bus.din_in;
                    3'd3:    ccr_q  <= CCR_WIDTH'(bus.din_in);
                    default: ctrl_q <= bus.din_in[2:0];
                endcase
            end
            if (locked_wr) wr_err_q <= 1'b1;

            if (rd_en) begin
                dout_q <= rd_data;
                if (bus.addr_in == 3'd5) wr_err_q <= 1'b0;
            end

            if (accept) begin
                count_q <= plr_q;
                rem_q   <= ccr_q;
                dir_q   <= 1'b1;
                hit_u_q <= 1'b0;
                hit_l_q <= 1'b0;
            end else if (busy && !stop_in) begin
                count_q <= step_count;
                dir_q   <= step_dir;
                if (cycle_done) begin
                    hit_u_q <= 1'b0;
                    hit_l_q <= 1'b0;
                    if (!cont) begin
                        rem_q <= rem_q - CcrOne;
                        ec_q  <= last_cycle;
                    end
                end else begin
                    hit_u_q <= hit_u_n;
                    hit_l_q <= hit_l_n;
                end
            end
        end
    end

endmodule
